// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register: valid/ready handshake, two-entry skid buffer, synchronous flush.
// Optional back-pressure counter enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_stage_skid #(
  parameter int unsigned       WIDTH      = 32,
  parameter logic [WIDTH-1:0]  RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [31:0]      stall_cycles
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             out_valid_q, in_ready_q;
  logic             load_main, load_skid, main_from_skid;

  // in_ready is 1 in EMPTY/ONE and out_valid is 1 in ONE/FULL, so the raw
  // handshake inputs already qualify as transfers inside each state arm.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_valid) begin
            load_main = 1'b1;
            state_d   = StOne;
          end
        end
        StOne: begin
          if (in_valid && out_ready) begin
            load_main = 1'b1;
          end else if (in_valid) begin
            load_skid = 1'b1;
            state_d   = StFull;
          end else if (out_ready) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_ready) begin
            main_from_skid = 1'b1;
            state_d        = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= RESET_DATA;
      skid_q      <= RESET_DATA;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != StEmpty);
      in_ready_q  <= (state_d != StFull);
      if (load_main) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating; flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= 32'd0;
    end else if (out_valid_q && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, elastic pipeline register for the RVX10-P datapath: the next generation of the fixed MEM/WB latch, carrying a WIDTH-bit payload with a valid/ready handshake, a two-entry skid buffer, and synchronous flush. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It lets a downstream stall back-pressure the upstream stage without a combinational ready path, and lets a hazard unit squash in-flight instructions.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (≥1); the caller packs {ALUResult, ReadData, Rd, PCPlus4, ...}
- RESET_DATA, '0, value loaded into both payload registers on reset

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream presents a valid payload
- in_data  input  WIDTH  upstream payload
- in_ready  output  1  stage can accept this cycle; registered, no dependence on out_ready
- out_valid  output  1  out_data holds a valid payload
- out_data  output  WIDTH  payload to downstream; registered
- out_ready  input  1  downstream consumes out_data this cycle
- occupancy  output  2  entries held: 0, 1 or 2
- stall_cycles  output  32  back-pressure counter (see Configuration)

## Operation
- Storage: main register (out_data/out_valid) and skid register (skid_data/skid_valid).
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- States, encoded by occupancy:
  - EMPTY (0)
  - ONE (1): main valid, skid empty
  - FULL (2): both valid
- EMPTY:
  - With a transfer in: main ← in_data, go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - In and out together: main ← in_data, stay in ONE.
  - Out only: go to EMPTY.
  - In only: skid ← in_data, go to FULL.
  - Neither: hold.
- FULL:
  - in_ready = 0, so no transfer in is possible.
  - With a transfer out: main ← skid, skid cleared, go to ONE.
  - Otherwise hold.
- in_ready = !skid_valid, i.e. occupancy != 2.
- Ordering: strict FIFO. The skid entry is always older than any later input and younger than main.
- flush has priority over every other event:
  - Next cycle: out_valid = 0, skid_valid = 0, occupancy = 0, in_ready = 1.
  - Any input presented in the flush cycle is dropped.
  - Payload registers keep their old contents; only the valid bits clear.
  - A downstream consumption in the flush cycle still counts as taken by downstream.
- Reset (asynchronous, any time including mid-transfer):
  - out_valid = 0, skid_valid = 0, in_ready = 1, occupancy = 0.
  - out_data = RESET_DATA, skid_data = RESET_DATA, stall_cycles = 0.
- out_data is only meaningful while out_valid = 1. Downstream must gate writes (e.g. RegWrite) with out_valid.

## Timing
- Latency: 1 cycle. A payload accepted at edge N is visible on out_data/out_valid after edge N.
- Throughput: 1 payload/cycle sustained while out_ready = 1.
- in_ready is a flop output. There is no combinational path between any input and any output.
- After a stall: when out_ready rises in FULL, in_ready returns to 1 one cycle later. No payload is lost or duplicated.
- All handshake signals are sampled on the rising edge of clk.
- reset acts immediately, independent of clk. Its deassertion must meet recovery time relative to clk.

## Configuration
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - stall_cycles increments every cycle with out_valid && !out_ready.
  - It saturates at 32'hFFFF_FFFF and does not wrap.
  - It clears only on reset; flush does not clear it.
- Undefined: stall_cycles is tied to 32'd0 and no counter logic is synthesised. Handshake behaviour is identical in both builds.

## Test plan
- Reset mid-stream:
  - Stimulus: fill to FULL, then pulse reset asynchronously between edges.
  - Response: immediately out_valid = 0, in_ready = 1, occupancy = 0, out_data = RESET_DATA.
- Pass-through, WIDTH=32:
  - Stimulus: in_valid = 1 with in_data = 0x10, 0x11, 0x12 on consecutive cycles, out_ready = 1.
  - Response: out_data = 0x10, 0x11, 0x12 on the next three cycles, occupancy = 1 throughout.
- Back-pressure:
  - Stimulus: out_ready = 0, push 0xA then 0xB.
  - Response: occupancy = 2 and in_ready = 0 after the second edge.
  - Then raise out_ready for 2 cycles: out_data = 0xA then 0xB, in order, with no drop or duplicate.
- Flush priority:
  - Stimulus: in FULL, assert flush together with in_valid = 1 (in_data = 0xC) and out_ready = 0.
  - Response: next cycle out_valid = 0, occupancy = 0, in_ready = 1, and 0xC never appears.
- Simultaneous in/out in ONE:
  - Stimulus: main = 0x5; present in_data = 0x6 with out_ready = 1.
  - Response: next cycle out_data = 0x6, occupancy = 1, skid unused.
- Stall counter (PIPE_SKID_STALL_CNT_EN defined):
  - Stimulus: hold out_valid = 1, out_ready = 0 for 7 cycles.
  - Response: stall_cycles = 7.
  - Force to 32'hFFFF_FFFE and stall 3 more cycles: reads 32'hFFFF_FFFF.
  - With the macro undefined: stall_cycles stays 0.
